// File: rtl/data_ram_ctrl_pkg.sv
// rtl/data_ram_ctrl_pkg.sv - shared FSM encodings, wait-counter sizing and byte-lane map
package data_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  localparam int WAIT_MAX = 7;
  localparam int CNT_W    = 3;

  // Low bit of each lane; byte offset 0 is the most significant byte (sel[3]).
  localparam int LANE_B0 = 24;
  localparam int LANE_B1 = 16;
  localparam int LANE_B2 = 8;
  localparam int LANE_B3 = 0;

  function automatic int lane_lsb(input int byte_ofs);
    int lsb;
    case (byte_ofs)
      0:       lsb = LANE_B0;
      1:       lsb = LANE_B1;
      2:       lsb = LANE_B2;
      default: lsb = LANE_B3;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// rtl/data_ram_bank.sv - one 8-bit lane of the data RAM, synchronous write and registered read
module data_ram_bank #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - MEM-stage data RAM responder with wait states and stall request
// Optional DATA_RAM_ADDR_ERR_EN adds err_o and out-of-range access suppression.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stallreq_o
`ifdef DATA_RAM_ADDR_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic               commit;

  logic               cap_we, cap_err;
  logic [3:0]         cap_sel;
  logic [ADDR_W-1:0]  cap_idx;
  logic [31:0]        cap_data;

  logic               cur_we, cur_err;
  logic [3:0]         cur_sel;
  logic [ADDR_W-1:0]  cur_idx;
  logic [31:0]        cur_data;

  logic               addr_err;
  logic [3:0]         lane_we;
  logic               rd_en;
  logic [31:0]        rdata;
  logic               zero_q;

`ifdef DATA_RAM_ADDR_ERR_EN
  assign addr_err = (addr_i >> (ADDR_W + 2)) != 32'd0;
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];
`else
  assign addr_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
`endif

  // With zero wait states the commit happens straight out of IDLE, so the live bus is used.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we   = we_i;
      cur_err  = addr_err;
      cur_sel  = sel_i;
      cur_idx  = addr_i[ADDR_W+1:2];
      cur_data = data_i;
    end else begin
      cur_we   = cap_we;
      cur_err  = cap_err;
      cur_sel  = cap_sel;
      cur_idx  = cap_idx;
      cur_data = cap_data;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ce_i) begin
          if (WAIT_EFF == 0) begin
            state_nx = ST_ACK;
            commit   = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            count_nx = CNT_W'(WAIT_EFF);
          end
        end
      end
      ST_WAIT: begin
        if (!ce_i) begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end else if (count <= CNT_W'(1)) begin
          state_nx = ST_ACK;
          count_nx = '0;
          commit   = 1'b1;
        end else begin
          count_nx = count - CNT_W'(1);
        end
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      zero_q <= 1'b1;
`ifdef DATA_RAM_ADDR_ERR_EN
      err_o  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (commit && (cur_err || !cur_we)) zero_q <= cur_err;
`ifdef DATA_RAM_ADDR_ERR_EN
      err_o <= commit && cur_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && ce_i) begin
      cap_we   <= we_i;
      cap_err  <= addr_err;
      cap_sel  <= sel_i;
      cap_idx  <= addr_i[ADDR_W+1:2];
      cap_data <= data_i;
    end
  end

  assign lane_we = {4{commit && cur_we && !cur_err}} & cur_sel;
  assign rd_en   = commit && !cur_we && !cur_err;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    localparam int LSB = lane_lsb(b);
    data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .we    (lane_we[LSB/8]),
      .re    (rd_en),
      .addr  (cur_idx),
      .wdata (cur_data[LSB+:8]),
      .rdata (rdata[LSB+:8])
    );
  end

  // The lane registers are not reset, so a flag masks them until the first good read.
  assign data_o     = zero_q ? 32'd0 : rdata;
  assign ack_o      = (state == ST_ACK);
  assign stallreq_o = ce_i && (state != ST_ACK);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - randomized bench for data_ram_ctrl at 0, 1 and 3 wait states
module tb_data_ram_ctrl;

  localparam int N  = 3;
  localparam int AW = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce    [N];
  logic        we    [N];
  logic [31:0] addr  [N];
  logic [3:0]  sel   [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ack   [N];
  logic        stall [N];
`ifdef DATA_RAM_ADDR_ERR_EN
  logic        err   [N];
`endif

  always #5 clk = ~clk;

  function automatic int wc_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_ram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))) dut (
      .clk        (clk),
      .rst        (rst_n),
      .ce_i       (ce[g]),
      .we_i       (we[g]),
      .addr_i     (addr[g]),
      .sel_i      (sel[g]),
      .data_i     (wdata[g]),
      .data_o     (rdata[g]),
      .ack_o      (ack[g]),
      .stallreq_o (stall[g])
`ifdef DATA_RAM_ADDR_ERR_EN
      ,
      .err_o      (err[g])
`endif
    );
  end

  logic [31:0] mem_m [int];
  logic [31:0] exp_d [N];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
`ifdef DATA_RAM_ADDR_ERR_EN
    return (a >> (AW + 2)) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int key_of(input int i, input logic [31:0] a);
    return i * (1 << AW) + int'((a >> 2) & ((32'd1 << AW) - 1));
  endfunction

  // Entered and left #1 after a rising edge; drop > 0 pulls ce low in that cycle.
  task automatic access(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int drop);
    int wc = wc_of(i);
    int ack_cyc = -1;
    int stalls = 0;
    bit e = is_err(a);
    int key = key_of(i, a);
    logic [31:0] tmp;
    ce[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; wdata[i] = d;
    for (int c = 0; c < wc + 4; c++) begin
      if (drop != 0 && c == drop) ce[i] = 1'b0;
      @(negedge clk);
      if (stall[i]) stalls++;
      if (ack[i]) begin
        ack_cyc = c;
        if (e) exp_d[i] = 32'd0;
        else if (!w) exp_d[i] = mem_m[key];
        else begin
          tmp = mem_m[key];
          for (int k = 0; k < 4; k++) if (s[k]) tmp[8*k +: 8] = d[8*k +: 8];
          mem_m[key] = tmp;
        end
        chk("ack_data", rdata[i], exp_d[i]);
`ifdef DATA_RAM_ADDR_ERR_EN
        chk("ack_err", err[i], e);
`endif
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    ce[i] = 1'b0;
    if (drop != 0) begin
      chk("flush_noack", ack_cyc, -1);
      chk("flush_stall", stalls, drop);
      chk("flush_data", rdata[i], exp_d[i]);
    end else begin
      chk("ack_latency", ack_cyc, wc + 1);
      chk("stall_len", stalls, wc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sel[i] = '0; wdata[i] = '0;
      exp_d[i] = '0;
    end
    #12;
    for (int i = 0; i < N; i++) begin
      chk("rst_ack", ack[i], 1'b0);
      chk("rst_stall", stall[i], 1'b0);
      chk("rst_data", rdata[i], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++)
      for (int w = 0; w < 9; w++)
        access(i, 1'b1, 32'(w * 4), 4'hF, 32'h1000_0000 + 32'(i * 256 + w), 0);

    access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    access(1, 1'b0, 32'h10, 4'h1, 32'h0, 0);
    chk("dir_full_word", rdata[1], 32'hDEADBEEF);
    idle(1);
    access(1, 1'b1, 32'h12, 4'b0100, 32'h5A5A5A5A, 0);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, 0);
    chk("dir_byte", rdata[1], 32'hDE5ABEEF);
    access(1, 1'b1, 32'h20, 4'hF, 32'h0, 0);
    access(1, 1'b1, 32'h20, 4'b0011, 32'h12341234, 0);
    idle(2);
    chk("dir_hold", rdata[1], 32'hDE5ABEEF);
    access(1, 1'b0, 32'h20, 4'hF, 32'h0, 0);
    chk("dir_half", rdata[1], 32'h00001234);
    access(1, 1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, 0);
    access(1, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    chk("dir_sel0", rdata[1], 32'h10000105);

    access(1, 1'b1, 32'h0008_0000, 4'hF, 32'hCAFEF00D, 0);
    access(1, 1'b0, 32'h0, 4'hF, 32'h0, 0);
`ifdef DATA_RAM_ADDR_ERR_EN
    chk("dir_oor", rdata[1], 32'h10000100);
`else
    chk("dir_alias", rdata[1], 32'hCAFEF00D);
`endif

    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
    access(0, 1'b1, 32'h10, 4'hF, 32'hA5A5C3C3, 0);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
    chk("dir_b2b", rdata[0], 32'hA5A5C3C3);

    access(2, 1'b1, 32'h14, 4'hF, 32'hBAD0BAD0, 2);
    idle(2);
    access(2, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    chk("dir_flush", rdata[2], 32'h10000205);

    for (int n = 0; n < 150; n++) begin
      int i = int'($urandom_range(0, N - 1));
      int wc = wc_of(i);
      logic [31:0] a = (32'($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      int drop = 0;
      if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 8191)) << 19);
      if (wc > 0 && $urandom_range(0, 5) == 0) drop = int'($urandom_range(1, wc));
      access(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, drop);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h18; sel[2] = 4'hF; wdata[2] = 32'h0BADF00D;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", ack[2], 1'b0);
    chk("arst_stall_ce", stall[2], 1'b1);
    for (int i = 0; i < N; i++) begin
      chk("arst_data", rdata[i], 32'd0);
      exp_d[i] = 32'd0;
`ifdef DATA_RAM_ADDR_ERR_EN
      chk("arst_err", err[i], 1'b0);
`endif
    end
    ce[2] = 1'b0;
    #1;
    chk("arst_stall", stall[2], 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(2, 1'b0, 32'h18, 4'hF, 32'h0, 0);
    for (int i = 0; i < N; i++) access(i, 1'b0, 32'h10, 4'hF, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Data-RAM responder at the far end of the MEM-stage load/store bus (ce/we/sel/addr/data out; read data in).
- Owns the data memory array and accepts byte-, halfword- and word-lane writes.
- Inserts a configurable number of wait states and raises a stall request to the pipeline controller until each access completes.
- Sits beside the MEM stage; its data_o drives the MEM stage's memory-read-data input.

Parameters:
- ADDR_W, 17, word-address bits; array depth is 2**ADDR_W words.
- WAIT_CYCLES, 1, extra wait states per access; legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ce_i  in  1  access request; held stable by the MEM stage while stallreq_o=1.
- we_i  in  1  1=write, 0=read.
- addr_i  in  32  byte address.
- sel_i  in  4  byte-lane enables; sel_i[3] = bits 31:24 = byte offset 0 (big-endian lanes).
- data_i  in  32  write data, already lane-replicated by the MEM stage.
- data_o  out  32  read data, registered.
- ack_o  out  1  access complete this cycle.
- stallreq_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wait counter=0; data_o=0; ack_o=0.
  - stallreq_o=0 once ce_i is low.
  - Memory contents are not cleared.
- FSM states IDLE, WAIT, ACK:
  - IDLE, ce_i=1: capture we/sel/word index/data. Go to WAIT with count=WAIT_CYCLES; go straight to ACK when WAIT_CYCLES=0.
  - WAIT: decrement count each cycle. When count reaches 0, next state is ACK, and at that edge the access commits:
    - Write: for each sel_i[k]=1, write the corresponding 8-bit lane.
    - Read: data_o <= full 32-bit word, all lanes regardless of sel_i.
  - From IDLE, the commit also happens on the IDLE->ACK edge when WAIT_CYCLES=0.
  - ACK: ack_o=1 for exactly one cycle, then return to IDLE unconditionally. A new request presented the next cycle starts a fresh access (no back-to-back merging).
- stallreq_o = ce_i AND (state != ACK), combinational.
- Latency: request visible in cycle 0; ack_o in cycle WAIT_CYCLES+1; stall lasts WAIT_CYCLES+1 cycles.
- Addressing:
  - Word index = addr_i[ADDR_W+1:2].
  - addr_i[1:0] is ignored; lane selection comes only from sel_i.
  - Upper address bits alias (see optional feature).
- ce_i dropped before commit (flush): return to IDLE next edge, no write performed, data_o unchanged, no ack_o.
- ce_i dropped in ACK: no effect; the commit already happened.
- we_i=1 with sel_i=0000: no bytes change; ack_o still generated.
- data_o holds its last read value across writes and idle cycles.
- Reset mid-access: abandon the access. An uncommitted write is lost; a committed write persists.

Optional Feature:
- Macro DATA_RAM_ADDR_ERR_EN.
- Defined: adds output err_o (1 bit, reset 0).
  - If addr_i[31:ADDR_W+2] is nonzero at capture, the access is flagged as out of range.
  - At commit: write suppressed and data_o <= 0.
  - err_o=1 together with ack_o in the ACK cycle.
- Undefined: no err_o port; upper bits are ignored and accesses alias into the array.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE=2'b00, WAIT=2'b01, ACK=2'b10).
  - WAIT_CYCLES maximum (7) and counter width (3).
  - Lane constants LANE_B0..LANE_B3 mapping sel bits to data bit ranges.
- Sub-module data_ram_bank: one 8-bit-wide, 2**ADDR_W-deep synchronous byte memory with write enable. Instantiated four times, one per lane.

Test Plan:
- WAIT_CYCLES=1; write addr 0x10, sel 1111, data 0xDEADBEEF, then read 0x10 -> stallreq_o high 2 cycles per access, ack_o in cycle 2, data_o=0xDEADBEEF.
- Byte write sel 0100, data 0x5A5A5A5A to 0x10 (holding 0xDEADBEEF); read back -> 0xDE5ABEEF.
- Halfword write sel 0011, data 0x12341234 to 0x20 (holding 0); read -> 0x00001234.
- WAIT_CYCLES=0; back-to-back read-write-read -> each ack_o one cycle after request; stallreq_o one cycle each.
- Write request with ce_i dropped during WAIT (WAIT_CYCLES=3) -> no ack_o, memory word unchanged on later read.
- With DATA_RAM_ADDR_ERR_EN, ADDR_W=17: write to 0x00080000 -> err_o=1 with ack_o, read of 0x00000000 unchanged. Without the macro -> the same access writes word 0.
- Assert rst low mid-WAIT -> outputs 0 asynchronously; FSM in IDLE after release.
